// File: rtl/sfp_pkg.sv
// Shared types and constants for the SFP row-normalisation sequencer.
// No logic; no latency; no backpressure.
package sfp_pkg;
   typedef enum logic [2:0] {
      IDLE,
      ACC,
      FLUSH,
      SYNC,
      DIV,
      DRAIN
   } state_t;

   localparam int FLUSH_CYC    = 2;
   localparam int DRAIN_CYC    = 2;
   localparam int DEF_NUM_ROWS = 8;
   localparam int DEF_ADDR_W   = 4;
endpackage

// File: rtl/sfp_issue_pipe.sv
// Two-stage shift of {rd_en, mode, addr} producing the SFP row strobes and output writes.
// acc/div one cycle after rd_en; fifo_ext_rd/out_wr_en two cycles after; no backpressure.
module sfp_issue_pipe #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic              mode_div,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              acc,
   output logic              div,
   output logic              fifo_ext_rd,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_wr_addr
);
   logic              vld1, div1, vld2, div2;
   logic [ADDR_W-1:0] addr1, addr2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld1  <= 1'b0;
         div1  <= 1'b0;
         addr1 <= '0;
         vld2  <= 1'b0;
         div2  <= 1'b0;
         addr2 <= '0;
      end else begin
         vld1  <= rd_en;
         div1  <= mode_div;
         addr1 <= rd_addr;
         vld2  <= vld1;
         div2  <= div1;
         addr2 <= addr1;
      end
   end

   assign acc         = vld1 & ~div1;
   assign div         = vld1 & div1;
   // The external pop and the output write both ride the second stage, alongside div_q in the SFP.
   assign fifo_ext_rd = vld2 & div2;
   assign out_wr_en   = vld2 & div2;
   assign out_wr_addr = addr2;
endmodule

// File: rtl/sfp_ctrl.sv
// Sequences one SFP normalisation pass: ACC, FLUSH, two-core SYNC barrier, DIV, DRAIN.
// start-to-done 2*NUM_ROWS+6 cycles with the peer already waiting; no backpressure beyond the barrier.
module sfp_ctrl
   import sfp_pkg::*;
#(
   parameter int NUM_ROWS     = DEF_NUM_ROWS,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int SYNC_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              psum_rd_en,
   output logic [ADDR_W-1:0] psum_rd_addr,
   output logic              acc,
   output logic              div,
   output logic              fifo_ext_rd,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_wr_addr,
   output logic              sync_req,
   input  logic              peer_sync_req,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int CNT_MAX = (SYNC_TIMEOUT > NUM_ROWS) ? SYNC_TIMEOUT : NUM_ROWS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              rd_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      base_d  = base_q;
      err_d   = err_q;
      done_d  = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               base_d  = base_addr;
               err_d   = 1'b0;
               state_d = ACC;
            end
         end
         ACC: begin
            rd_en = 1'b1;
            if (cnt_q == CNT_W'(NUM_ROWS - 1)) begin
               cnt_d   = '0;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
               cnt_d   = '0;
               state_d = SYNC;
            end
         end
         SYNC: begin
            // The peer sees the same overlap, so both cores leave SYNC on the same edge.
            if (peer_sync_req) begin
               cnt_d   = '0;
               state_d = DIV;
            end else if (SYNC_TIMEOUT != 0 && cnt_q == CNT_W'(SYNC_TIMEOUT)) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (SYNC_TIMEOUT == 0) begin
               cnt_d = cnt_q;
            end
         end
         DIV: begin
            rd_en = 1'b1;
            if (cnt_q == CNT_W'(NUM_ROWS - 1)) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      if (start && state_q != IDLE) err_d = 1'b1;
   end

   assign psum_rd_en   = rd_en;
   assign psum_rd_addr = rd_en ? base_q + ADDR_W'(cnt_q) : '0;
   assign sync_req     = (state_q == SYNC);
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign err          = err_q;

   sfp_issue_pipe #(
      .ADDR_W(ADDR_W)
   ) u_pipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_en      (rd_en),
      .mode_div   (state_q == DIV),
      .rd_addr    (psum_rd_addr),
      .acc        (acc),
      .div        (div),
      .fifo_ext_rd(fifo_ext_rd),
      .out_wr_en  (out_wr_en),
      .out_wr_addr(out_wr_addr)
   );
endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: basic pass, wrap, late peer, sync timeout, start while busy, async reset.
module tb_sfp_ctrl;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] base_addr = 4'd0;
   logic       tie = 1'b1;
   logic       peer_man = 1'b0;
   logic       psum_rd_en, acc, div, fifo_ext_rd, out_wr_en, sync_req, peer_sync_req, busy, done, err;
   logic [3:0] psum_rd_addr, out_wr_addr;

   logic       start_to = 1'b0;
   logic       rd_en_to, acc_to, div_to, ext_to, wr_to, sync_to, busy_to, done_to, err_to;
   logic [3:0] rd_addr_to, wr_addr_to;

   assign peer_sync_req = tie ? sync_req : peer_man;

   sfp_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .acc(acc), .div(div),
      .fifo_ext_rd(fifo_ext_rd), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
      .sync_req(sync_req), .peer_sync_req(peer_sync_req), .busy(busy), .done(done), .err(err)
   );

   sfp_ctrl #(.SYNC_TIMEOUT(10)) dut_to (
      .clk(clk), .reset_n(reset_n), .start(start_to), .base_addr(4'd0),
      .psum_rd_en(rd_en_to), .psum_rd_addr(rd_addr_to), .acc(acc_to), .div(div_to),
      .fifo_ext_rd(ext_to), .out_wr_en(wr_to), .out_wr_addr(wr_addr_to),
      .sync_req(sync_to), .peer_sync_req(1'b0), .busy(busy_to), .done(done_to), .err(err_to)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int t0 = 0;
   int tsync = 0;
   logic clr = 1'b0;

   int acc_n, div_n, ext_n, wr_n, rd_n, done_n, both_n, div_to_n, done_to_n;
   int acc_first, acc_last, div_first, div_last, ext_first, done_cyc;
   int wr_log [16];
   int rd_log [32];

   always @(negedge clk) begin
      if (clr) begin
         acc_n = 0; div_n = 0; ext_n = 0; wr_n = 0; rd_n = 0; done_n = 0; both_n = 0;
         div_to_n = 0; done_to_n = 0;
         acc_first = -1; acc_last = -1; div_first = -1; div_last = -1; ext_first = -1;
         done_cyc = -1;
      end else if (reset_n) begin
         if (acc) begin
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc;
            acc_n++;
         end
         if (div) begin
            if (div_first < 0) div_first = cyc;
            div_last = cyc;
            div_n++;
         end
         if (fifo_ext_rd) begin
            if (ext_first < 0) ext_first = cyc;
            ext_n++;
         end
         if (out_wr_en) begin
            if (wr_n < 16) wr_log[wr_n] = int'(out_wr_addr);
            wr_n++;
         end
         if (psum_rd_en) begin
            if (rd_n < 32) rd_log[rd_n] = int'(psum_rd_addr);
            rd_n++;
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
         if (acc && div) both_n++;
         if (div_to) div_to_n++;
         if (done_to) done_to_n++;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] base);
      base_addr = base;
      start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 120 && done_n == 0; i++) step();
      chk(tag, done_n, 1);
      step();
   endtask

   task automatic wait_div(input string tag);
      for (int i = 0; i < 60 && div !== 1'b1; i++) step();
      chk(tag, int'(div), 1);
   endtask

   task automatic check_addrs(input string tag, input logic [3:0] base);
      logic [3:0] a;
      int bad;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         a = base + 4'(i);
         if (wr_log[i] != int'(a)) bad++;
         if (rd_log[i] != int'(a)) bad++;
         if (rd_log[i+8] != int'(a)) bad++;
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      // reset state
      step();
      chk("reset_outputs", int'({psum_rd_en, acc, div, fifo_ext_rd, out_wr_en, sync_req, busy, done, err}), 0);
      chk("reset_addrs", int'({psum_rd_addr, out_wr_addr}), 0);
      reset_n = 1'b1;
      step();
      chk("idle_busy", int'(busy), 0);

      // 1: basic pass, peer tied
      clear_log();
      pulse_start(4'd0);
      chk("busy_after_start", int'(busy), 1);
      wait_done("basic_done_seen");
      chk("basic_acc_n", acc_n, 8);
      chk("basic_acc_first", acc_first - t0, 2);
      chk("basic_acc_last", acc_last - t0, 9);
      chk("basic_div_first", div_first - t0, 13);
      chk("basic_div_last", div_last - t0, 20);
      chk("basic_ext_n", ext_n, 8);
      chk("basic_ext_first", ext_first - t0, 14);
      chk("basic_wr_n", wr_n, 8);
      chk("basic_rd_n", rd_n, 16);
      chk("basic_done_cyc", done_cyc - t0, 22);
      chk("basic_acc_div_overlap", both_n, 0);
      check_addrs("basic_addrs", 4'd0);
      chk("basic_busy_after", int'(busy), 0);
      chk("basic_err", int'(err), 0);

      // 2: address wrap
      clear_log();
      pulse_start(4'd12);
      wait_done("wrap_done_seen");
      chk("wrap_wr_n", wr_n, 8);
      check_addrs("wrap_addrs", 4'd12);

      // 3: late peer
      tie = 1'b0;
      peer_man = 1'b0;
      clear_log();
      pulse_start(4'd3);
      for (int i = 0; i < 40 && sync_req !== 1'b1; i++) step();
      chk("late_sync_seen", int'(sync_req), 1);
      tsync = cyc;
      chk("late_sync_cyc", tsync - t0, 11);
      repeat (40) step();
      chk("late_sync_held", int'(sync_req), 1);
      chk("late_no_div_yet", div_n, 0);
      peer_man = 1'b1;
      tsync = cyc;
      step();
      peer_man = 1'b0;
      chk("late_sync_dropped", int'(sync_req), 0);
      wait_done("late_done_seen");
      chk("late_div_first", div_first - tsync, 2);
      chk("late_done_cyc", done_cyc - tsync, 11);
      chk("late_wr_n", wr_n, 8);
      chk("late_err", int'(err), 0);
      tie = 1'b1;

      // 4: sync timeout on the SYNC_TIMEOUT=10 instance
      clear_log();
      start_to = 1'b1;
      t0 = cyc;
      step();
      start_to = 1'b0;
      repeat (20) step();
      chk("to_sync_before", int'(sync_to), 1);
      chk("to_err_before", int'(err_to), 0);
      step();
      chk("to_err_set", int'(err_to), 1);
      chk("to_idle", int'(busy_to), 0);
      chk("to_sync_dropped", int'(sync_to), 0);
      repeat (5) step();
      chk("to_no_div", div_to_n, 0);
      chk("to_no_done", done_to_n, 0);
      start_to = 1'b1;
      step();
      start_to = 1'b0;
      chk("to_err_cleared", int'(err_to), 0);
      chk("to_restart_busy", int'(busy_to), 1);

      // 5: start while busy
      clear_log();
      pulse_start(4'd0);
      chk("busy_err_clear_on_start", int'(err), 0);
      wait_div("busy_div_seen");
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_err_set", int'(err), 1);
      wait_done("busy_done_seen");
      chk("busy_wr_n", wr_n, 8);
      check_addrs("busy_addrs", 4'd0);
      chk("busy_err_sticky", int'(err), 1);

      // 6: async reset mid-DIV
      clear_log();
      pulse_start(4'd5);
      wait_div("rst_div_seen");
      repeat (3) step();
      chk("rst_wr_active", int'(out_wr_en), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_async_outputs", int'({psum_rd_en, acc, div, fifo_ext_rd, out_wr_en, sync_req, busy, done, err}), 0);
      chk("rst_async_addrs", int'({psum_rd_addr, out_wr_addr}), 0);
      step();
      step();
      reset_n = 1'b1;
      clear_log();
      pulse_start(4'd0);
      wait_done("rst_done_seen");
      chk("rst_wr_n", wr_n, 8);
      chk("rst_done_cyc", done_cyc - t0, 22);
      check_addrs("rst_addrs", 4'd0);
      chk("rst_err", int'(err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sfp_ctrl.md
Name: sfp_ctrl

Overview:
- Sequencer for one SFP row-normalisation pass on a core.
- Pass 1 (ACC) streams NUM_ROWS psum rows from psum memory into the SFP row with acc high, filling the local and external abs-sum FIFOs.
- A two-core barrier aligns this core with its peer.
- Pass 2 (DIV) re-streams the same rows with div high, pops both sum FIFOs in lockstep, and writes normalised rows to output memory.

Parameters:
- NUM_ROWS, 8, rows per pass; legal range 1..16, bounded by the sum-FIFO depth.
- ADDR_W, 4, psum and output memory address width.
- SYNC_TIMEOUT, 255, maximum cycles spent in SYNC before an error is raised; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- base_addr  in  ADDR_W  first psum row address; latched on start.
- psum_rd_en  out  1  psum memory read enable; read data is valid the next cycle.
- psum_rd_addr  out  ADDR_W  psum read address.
- acc  out  1  to SFP row accumulate.
- div  out  1  to SFP row divide.
- fifo_ext_rd  out  1  to SFP row; pops the external sum FIFO toward the peer.
- out_wr_en  out  1  output memory write enable.
- out_wr_addr  out  ADDR_W  output write address.
- sync_req  out  1  barrier request to the peer.
- peer_sync_req  in  1  the peer's sync_req.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a pass completes.
- err  out  1  sticky error flag; cleared on start or reset.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, and every output is 0. Reset is allowed mid-pass; any partial FIFO contents are the datapath's concern.
- IDLE:
  - start latches base_addr, clears err, and moves to ACC.
  - start while busy is ignored and sets err.
- ACC:
  - psum_rd_en=1 for NUM_ROWS cycles, with addresses base_addr..base_addr+NUM_ROWS-1.
  - Addresses wrap modulo 2^ADDR_W.
  - acc is psum_rd_en delayed by one cycle (memory latency).
  - After the last read the controller goes to FLUSH.
- FLUSH: two cycles (acc tail plus the SFP's registered fifo_wr), guaranteeing the last sum has been written before the barrier. Then go to SYNC.
- SYNC:
  - sync_req=1.
  - When sync_req and peer_sync_req are both high in the same cycle, go to DIV next cycle. The peer makes the identical decision, so both cores enter DIV on the same edge.
  - sync_req drops on leaving SYNC.
  - With the timeout enabled, if the counter reaches SYNC_TIMEOUT: set err, drop sync_req, go to IDLE with no done pulse.
- DIV:
  - psum_rd_en=1 for NUM_ROWS cycles, reissuing the same addresses.
  - div is psum_rd_en delayed by 1.
  - fifo_ext_rd is div delayed by 1, aligned with the SFP's internal div_q pop, so local and peer sums advance together.
  - out_wr_en is div delayed by 1, with out_wr_addr equal to the read address delayed by 2.
  - After the last read, go to DRAIN.
- DRAIN: wait until the delayed div, fifo_ext_rd and out_wr_en pipelines are empty (2 cycles), then pulse done=1 for 1 cycle and go to IDLE.
- Row counter: 0..NUM_ROWS-1, reset on each phase entry. The same counter serves the sync timeout.
- Counts per pass: exactly NUM_ROWS acc cycles, NUM_ROWS div cycles, NUM_ROWS fifo_ext_rd cycles and NUM_ROWS writes, with no gaps inside a phase.
- acc and div are never high in the same cycle.
- Latency from start to done with the peer already waiting: 1 + N (ACC) + 2 (FLUSH) + 1 (SYNC) + N (DIV) + 2 (DRAIN) = 2N+6 cycles. N=8 gives 22.
- peer_sync_req outside SYNC is ignored.

Decomposition:
- Shared package sfp_pkg holds:
  - the state enum: IDLE, ACC, FLUSH, SYNC, DIV, DRAIN;
  - FLUSH_CYC=2 and DRAIN_CYC=2;
  - the default NUM_ROWS and ADDR_W.
- One natural sub-module, sfp_issue_pipe: a 2-stage shift of {rd_en, addr} that generates acc/div, fifo_ext_rd, out_wr_en and out_wr_addr.

Test Plan:
1. Basic pass: N=8, base_addr=0, peer_sync_req tied to sync_req.
   - acc high cycles 2-9.
   - div high cycles 13-20; writes to addresses 0..7.
   - done at cycle 22; busy low afterwards.
2. Wrap: base_addr=12, ADDR_W=4.
   - Read and write addresses are 12,13,14,15,0,1,2,3.
   - Exactly 8 writes.
3. Late peer: peer_sync_req rises 40 cycles after sync_req.
   - div starts exactly 2 cycles after the overlap (next-cycle DIV entry plus 1-cycle read latency).
   - done follows 8+2 cycles later.
4. Timeout: SYNC_TIMEOUT=10, peer never ready.
   - err=1, state IDLE, no div, no done.
   - The next start clears err.
5. start while busy: pulse start during DIV.
   - err=1; the current pass is unaffected and still yields 8 writes and done.
6. Async reset: drop reset_n in the middle of DIV.
   - All outputs are 0 immediately, without waiting for a clock edge.
   - After release, a new start runs a full clean pass.
